// File: rtl/i2c_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cmd_ctrl
// Purpose  : Queues host I2C commands, sequences them into an I2C master and
//            queues one {ack-error, byte} result per command, in order.
// Option   : I2C_CMD_ERR_CNT_EN enables the saturating ack-error counter.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cmd_ctrl #(
    parameter int CMD_DEPTH = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_err,
    output logic       m_newd,
    output logic [6:0] m_addr,
    output logic       m_op,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_busy,
    input  logic       m_ack_err,
    input  logic       m_done,
    output logic       idle,
    output logic [7:0] err_cnt
);

    localparam int CW = $clog2(CMD_DEPTH);
    localparam int RW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_STORE     = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Command FIFO: {addr, op, data}; pointers carry an extra wrap bit.
    logic [15:0] cmd_mem_q [CMD_DEPTH];
    logic [CW:0] cmd_wr_q, cmd_rd_q;
    logic        cmd_empty, cmd_full, cmd_push, cmd_pop;

    assign cmd_empty = (cmd_wr_q == cmd_rd_q);
    assign cmd_full  = (cmd_wr_q[CW] != cmd_rd_q[CW]) &&
                       (cmd_wr_q[CW-1:0] == cmd_rd_q[CW-1:0]);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;

    logic [8:0]  rx_mem_q [RX_DEPTH];
    logic [RW:0] rx_wr_q, rx_rd_q;
    logic        rx_empty, rx_full, rx_push, rx_pop;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RW] != rx_rd_q[RW]) &&
                      (rx_wr_q[RW-1:0] == rx_rd_q[RW-1:0]);
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    // Gate the head so outputs read zero while the FIFO is empty.
    assign rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[RW-1:0]][7:0];
    assign rx_err   = rx_empty ? 1'b0  : rx_mem_q[rx_rd_q[RW-1:0]][8];

    logic [6:0] m_addr_q, m_addr_d;
    logic       m_op_q, m_op_d;
    logic [7:0] m_din_q, m_din_d;
    logic       res_err_q, res_err_d;
    logic [7:0] res_byte_q, res_byte_d;

    assign m_addr = m_addr_q;
    assign m_op   = m_op_q;
    assign m_din  = m_din_q;
    assign m_newd = (state_q == S_ISSUE);
    assign idle   = cmd_empty && rx_empty && (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        m_addr_d   = m_addr_q;
        m_op_d     = m_op_q;
        m_din_d    = m_din_q;
        res_err_d  = res_err_q;
        res_byte_d = res_byte_q;
        cmd_pop    = 1'b0;
        rx_push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop  = 1'b1;
                    m_addr_d = cmd_mem_q[cmd_rd_q[CW-1:0]][15:9];
                    m_op_d   = cmd_mem_q[cmd_rd_q[CW-1:0]][8];
                    m_din_d  = cmd_mem_q[cmd_rd_q[CW-1:0]][7:0];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (m_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (m_done) begin
                    res_err_d  = m_ack_err;
                    res_byte_d = m_op_q ? m_dout : 8'h00;
                    state_d    = S_STORE;
                end
            end
            S_STORE: begin
                if (!rx_full) begin
                    rx_push = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            m_addr_q   <= 7'h00;
            m_op_q     <= 1'b0;
            m_din_q    <= 8'h00;
            res_err_q  <= 1'b0;
            res_byte_q <= 8'h00;
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            m_addr_q   <= m_addr_d;
            m_op_q     <= m_op_d;
            m_din_q    <= m_din_d;
            res_err_q  <= res_err_d;
            res_byte_q <= res_byte_d;
            if (cmd_push) cmd_wr_q <= cmd_wr_q + {{CW{1'b0}}, 1'b1};
            if (cmd_pop)  cmd_rd_q <= cmd_rd_q + {{CW{1'b0}}, 1'b1};
            if (rx_push)  rx_wr_q  <= rx_wr_q + {{RW{1'b0}}, 1'b1};
            if (rx_pop)   rx_rd_q  <= rx_rd_q + {{RW{1'b0}}, 1'b1};
        end
    end

    // Storage arrays are not reset; emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q[CW-1:0]] <= {cmd_addr, cmd_op, cmd_data};
        if (rx_push)  rx_mem_q[rx_wr_q[RW-1:0]]   <= {res_err_q, res_byte_q};
    end

`ifdef I2C_CMD_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else if (rx_push && res_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cmd_ctrl
// Purpose  : Scoreboard bench for i2c_cmd_ctrl with a behavioural I2C master.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_op = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       rx_valid, rx_err, m_newd, m_op, idle;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data, m_din, err_cnt;
    logic [6:0] m_addr;
    logic [7:0] m_dout = 8'h00;
    logic       m_busy = 1'b0, m_ack_err = 1'b0, m_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int newd_cnt = 0;

    logic       nack_mode = 1'b0;
    logic       master_hold = 1'b0;
    logic       hold_done = 1'b0;

    logic [15:0] exp_iss[$];
    logic [8:0]  exp_rx[$];

    i2c_cmd_ctrl #(.CMD_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_err(rx_err),
        .m_newd(m_newd), .m_addr(m_addr), .m_op(m_op), .m_din(m_din),
        .m_dout(m_dout), .m_busy(m_busy), .m_ack_err(m_ack_err), .m_done(m_done),
        .idle(idle), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Slave read data is a fixed function of the address: 0x50 -> 0x3C.
    function automatic logic [7:0] slave_byte(input logic [6:0] a);
        return {1'b0, a} ^ 8'h6C;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_newd) begin
                while (master_hold) @(negedge clk);
                m_busy = 1'b1;
                repeat (2) @(negedge clk);
                while (hold_done) @(negedge clk);
                m_dout    = slave_byte(m_addr);
                m_ack_err = nack_mode;
                m_done    = 1'b1;
                @(negedge clk);
                m_done    = 1'b0;
                m_busy    = 1'b0;
                m_ack_err = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_newd) begin
            newd_cnt++;
            checks++;
            if (exp_iss.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: m_newd with addr=%h, none expected", m_addr);
            end else begin
                logic [15:0] e;
                e = exp_iss.pop_front();
                if ({m_addr, m_op, m_op ? 8'h00 : m_din} !== e) begin
                    errors++;
                    $display("FAIL issue_fields: got addr=%h op=%b din=%h, want addr=%h op=%b din=%h",
                             m_addr, m_op, m_din, e[15:9], e[8], e[7:0]);
                end
            end
        end
        if (rst_n && rx_valid && rx_ready) begin
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got err=%b data=%h, none expected", rx_err, rx_data);
            end else begin
                logic [8:0] r;
                r = exp_rx.pop_front();
                if ({rx_err, rx_data} !== r) begin
                    errors++;
                    $display("FAIL result: got err=%b data=%h, want err=%b data=%h",
                             rx_err, rx_data, r[8], r[7:0]);
                end
            end
        end
    end

    task automatic send_cmd(input logic [6:0] a, input logic op, input logic [7:0] d,
                            output logic accepted);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_op    = op;
        cmd_data  = d;
        accepted  = cmd_ready;
        if (accepted) begin
            exp_iss.push_back({a, op, op ? 8'h00 : d});
            exp_rx.push_back({nack_mode, op ? slave_byte(a) : 8'h00});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(idle && exp_rx.size() == 0 && exp_iss.size() == 0 && !m_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_timeout: idle=%b pending results=%0d, want idle with none pending",
                     name, idle, exp_rx.size());
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1;
        chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_rx_valid",  {7'd0, rx_valid},  8'd0);
        chk("rst_rx_data",   rx_data,           8'h00);
        chk("rst_rx_err",    {7'd0, rx_err},    8'd0);
        chk("rst_idle",      {7'd0, idle},      8'd1);
        chk("rst_m_newd",    {7'd0, m_newd},    8'd0);
        chk("rst_m_addr",    {1'b0, m_addr},    8'h00);
        chk("rst_m_op",      {7'd0, m_op},      8'd0);
        chk("rst_m_din",     m_din,             8'h00);
        chk("rst_err_cnt",   err_cnt,           8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        logic acc;
        int n0;
        rx_ready = 1'b1;
        n0 = newd_cnt;
        send_cmd(7'h50, 1'b0, 8'hA5, acc);
        wait_idle("write");
        chk("write_newd_pulses", 8'(newd_cnt - n0), 8'd1);
    endtask

    task automatic test_read();
        logic acc;
        send_cmd(7'h50, 1'b1, 8'h00, acc);
        wait_idle("read");
        chk("read_idle_after_pop", {7'd0, idle}, 8'd1);
    endtask

    task automatic test_nack();
        logic acc;
        nack_mode = 1'b1;
        send_cmd(7'h22, 1'b0, 8'h5A, acc);
        wait_idle("nack");
        nack_mode = 1'b0;
`ifdef I2C_CMD_ERR_CNT_EN
        chk("nack_err_cnt", err_cnt, 8'd1);
`else
        chk("nack_err_cnt", err_cnt, 8'd0);
`endif
    endtask

    task automatic test_latency();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 7'h11; cmd_op = 1'b0; cmd_data = 8'h77;
        exp_iss.push_back({7'h11, 1'b0, 8'h77});
        exp_rx.push_back({1'b0, 8'h00});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("latency_n1", {7'd0, m_newd}, 8'd0);
        @(negedge clk);
        chk("latency_n2", {7'd0, m_newd}, 8'd1);
        wait_idle("latency");
    endtask

    task automatic test_cmd_full();
        logic acc;
        master_hold = 1'b1;
        send_cmd(7'h30, 1'b1, 8'h00, acc);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send_cmd(7'h31 + 7'(i), 1'(i & 1), 8'h10 + 8'(i), acc);
            chk($sformatf("full_accept_%0d", i), {7'd0, acc}, (i < 4) ? 8'd1 : 8'd0);
        end
        chk("full_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        master_hold = 1'b0;
        wait_idle("cmd_full");
    endtask

    task automatic test_rx_full();
        logic acc;
        int n0, acc_n, stall_n;
        rx_ready = 1'b0;
        n0 = newd_cnt;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            send_cmd(7'h40 + 7'(i), 1'(~i & 1), 8'hC0 + 8'(i), acc);
            if (acc) acc_n++;
        end
        stall_n = (acc_n > 5) ? 5 : acc_n;
        repeat (80) @(negedge clk);
        chk("rxfull_issued", 8'(newd_cnt - n0), 8'(stall_n));
        chk("rxfull_rx_valid", {7'd0, rx_valid}, 8'd1);
        chk("rxfull_not_idle", {7'd0, idle}, 8'd0);
        repeat (20) @(negedge clk);
        chk("rxfull_still_stalled", 8'(newd_cnt - n0), 8'(stall_n));
        rx_ready = 1'b1;
        wait_idle("rx_full");
        chk("rxfull_all_issued", 8'(newd_cnt - n0), 8'(acc_n));
    endtask

    task automatic test_reset_inflight();
        logic acc;
        int n;
        hold_done = 1'b1;
        send_cmd(7'h66, 1'b1, 8'h00, acc);
        n = 0;
        while (!m_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("inflight_busy_seen", {7'd0, m_busy}, 8'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        void'(exp_rx.pop_back());
        #1;
        chk("inflight_rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        chk("inflight_rst_rx_valid",  {7'd0, rx_valid},  8'd0);
        chk("inflight_rst_idle",      {7'd0, idle},      8'd1);
        chk("inflight_rst_m_addr",    {1'b0, m_addr},    8'h00);
        chk("inflight_rst_err_cnt",   err_cnt,           8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        hold_done = 1'b0;
        n = 0;
        while (m_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("inflight_no_result", {7'd0, rx_valid}, 8'd0);
        chk("inflight_idle_after", {7'd0, idle}, 8'd1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_latency();
        test_cmd_full();
        test_rx_full();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
